// File: rtl/mm_defs_pkg.sv
// Shared definitions for the mm matrix-multiply block family: element format,
// default matrix shape, bench clock period and index-width helper.
package mm_defs;
    localparam int FP_WIDTH     = 32;
    localparam int M_DEF        = 3;
    localparam int N_DEF        = 3;
    localparam int CLOCK_PERIOD = 10;

    typedef logic [FP_WIDTH-1:0] float_t;

    // Index fields stay at least one bit wide so 1x1 builds remain legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mm_index_counter.sv
// Row-major row/column wrap counter with a parallel linear element index.
// Shared by the matrix loader and unloader.
module mm_index_counter
    import mm_defs::*;
#(
    parameter int ROWS = M_DEF,
    parameter int COLS = N_DEF,
    parameter int RW   = idx_w(ROWS),
    parameter int CW   = idx_w(COLS),
    parameter int LW   = idx_w(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [LW-1:0] lin,
    output logic          last
);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [LW-1:0] r_lin;
    logic          w_row_end;
    logic          w_col_end;

    assign w_row_end = (r_row == ROW_MAX);
    assign w_col_end = (r_col == COL_MAX);

    // The linear index tracks row*COLS+col by counting, keeping the read mux free of multipliers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
            r_lin <= '0;
        end else if (clk_en) begin
            if (clr) begin
                r_row <= '0;
                r_col <= '0;
                r_lin <= '0;
            end else if (inc) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + 1'b1;
                    r_lin <= w_row_end ? '0 : r_lin + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                    r_lin <= r_lin + 1'b1;
                end
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign lin  = r_lin;
    assign last = w_row_end && w_col_end;
endmodule

// File: rtl/mm_matrix_unloader.sv
// Captures a completed MxN result matrix in one cycle and streams it out
// row-major, one element per valid/ready transfer, honouring clk_en stalls.
module mm_matrix_unloader
    import mm_defs::*;
#(
    parameter int M        = M_DEF,
    parameter int N        = N_DEF,
    parameter int FP_WIDTH = mm_defs::FP_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      load_req,
    input  logic [M*N*FP_WIDTH-1:0]   load_matrix,
    output logic                      load_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FP_WIDTH-1:0]       out_data,
    output logic [idx_w(M)-1:0]       out_row,
    output logic [idx_w(N)-1:0]       out_col,
    output logic                      out_last,
    output logic                      busy
);
    localparam int EW = idx_w(M * N);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [M*N*FP_WIDTH-1:0]   r_buf;
    logic [EW-1:0]             w_lin;
    logic                      w_last;
    logic                      w_load;
    logic                      w_xfer;
    logic                      w_done;
    logic [FP_WIDTH-1:0]       w_elems [1<<EW];

    assign w_load = load_req && load_ready;
    assign w_xfer = out_valid && out_ready;
    assign w_done = w_xfer && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else if (clk_en)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_load) w_next = S_STREAM;
            S_STREAM: if (w_done) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_last   = 1'b0;
        case (r_state)
            S_IDLE:   load_ready = clk_en;
            S_STREAM: begin
                out_valid = clk_en;
                busy      = 1'b1;
                out_last  = w_last;
            end
            default: ;
        endcase
    end

    // Buffer is only written on an accepted load, so offers during STREAM never disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_buf <= '0;
        else if (w_load)
            r_buf <= load_matrix;
    end

    mm_index_counter #(
        .ROWS (M),
        .COLS (N)
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .clr    (w_load || w_done),
        .inc    (w_xfer),
        .row    (out_row),
        .col    (out_col),
        .lin    (w_lin),
        .last   (w_last)
    );

    // Pad the element table to a power of two so the read index can never fall off the end.
    for (genvar e = 0; e < (1 << EW); e++) begin : g_el
        if (e < M * N) begin : g_v
            assign w_elems[e] = r_buf[e*FP_WIDTH +: FP_WIDTH];
        end else begin : g_z
            assign w_elems[e] = '0;
        end
    end

    assign out_data = w_elems[w_lin];
endmodule

// File: tb/tb_mm_matrix_unloader.sv
// Directed bench for mm_matrix_unloader: 3x3 streaming, backpressure, clk_en
// stalls, ignored loads, mid-stream reset, plus a 1x1 build.
module tb_mm_matrix_unloader;
    import mm_defs::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic         load_req;
    logic [287:0] load_matrix;
    logic         load_ready;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         out_last;
    logic         busy;

    logic         clk_en1;
    logic         load_req1;
    logic [31:0]  load_matrix1;
    logic         load_ready1;
    logic         out_valid1;
    logic         out_ready1;
    logic [31:0]  out_data1;
    logic [0:0]   out_row1;
    logic [0:0]   out_col1;
    logic         out_last1;
    logic         busy1;

    always #(CLOCK_PERIOD/2) clk = ~clk;

    mm_matrix_unloader #(.M(3), .N(3), .FP_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .load_req(load_req),
        .load_matrix(load_matrix), .load_ready(load_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_last(out_last), .busy(busy)
    );

    mm_matrix_unloader #(.M(1), .N(1), .FP_WIDTH(32)) dut1 (
        .clk(clk), .rst(rst), .clk_en(clk_en1), .load_req(load_req1),
        .load_matrix(load_matrix1), .load_ready(load_ready1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1), .out_row(out_row1),
        .out_col(out_col1), .out_last(out_last1), .busy(busy1)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    float_t vals [9] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                         32'h40800000, 32'h40A00000, 32'h40C00000,
                         32'h40E00000, 32'h41000000, 32'h41100000};

    float_t exp_q [$];
    int     n_acc = 0;

    // Reference stream: each presented element must match the head of the expected
    // queue, with row/col/last derived from the running accept count.
    always @(negedge clk) begin : mon
        int k;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_elem", 64'(out_valid), 64'd0);
            end else begin
                k = n_acc % 9;
                chk("data", 64'(out_data), 64'(exp_q[0]));
                chk("row",  64'(out_row),  64'(k / 3));
                chk("col",  64'(out_col),  64'(k % 3));
                chk("last", 64'(out_last), 64'(k == 8));
                if (out_ready) begin
                    exp_q.delete(0);
                    n_acc++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_matrix(input float_t v [9]);
        for (int i = 0; i < 9; i++) load_matrix[i*32 +: 32] = v[i];
    endtask

    task automatic expect_vals();
        for (int i = 0; i < 9; i++) exp_q.push_back(vals[i]);
    endtask

    task automatic do_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy && c < 200) begin
            step();
            c++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        float_t neg2 [9];
        int c;
        for (int i = 0; i < 9; i++) neg2[i] = 32'hC0000000;

        rst = 1'b1; clk_en = 1'b1; load_req = 1'b0; out_ready = 1'b0; load_matrix = '0;
        clk_en1 = 1'b1; load_req1 = 1'b0; out_ready1 = 1'b0; load_matrix1 = '0;
        #3;
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_out_last",   64'(out_last),   64'd0);
        chk("rst_out_data",   64'(out_data),   64'd0);
        chk("rst_row_col",    64'({out_row, out_col}), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Full-rate stream
        exp_q.delete(); n_acc = 0; expect_vals();
        set_matrix(vals);
        out_ready = 1'b1;
        do_load();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("stream_ready_low", 64'(load_ready), 64'd0);
        c = 1;
        while (out_valid && c < 50) begin
            step();
            if (out_valid) c++;
        end
        chk("stream_len",  64'(c), 64'd9);
        chk("ready_back",  64'(load_ready), 64'd1);
        chk("busy_idle",   64'(busy), 64'd0);
        chk("acc_full",    64'(n_acc), 64'd9);

        // Backpressure pattern 1,0,0,1
        exp_q.delete(); n_acc = 0; expect_vals();
        out_ready = 1'b1;
        do_load();
        c = 0;
        while (busy && c < 200) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            step();
            c++;
        end
        chk("bp_idle", 64'(busy), 64'd0);
        chk("bp_acc",  64'(n_acc), 64'd9);
        chk("bp_left", 64'(exp_q.size()), 64'd0);

        // clk_en stall after the third transfer
        exp_q.delete(); n_acc = 0; expect_vals();
        out_ready = 1'b1;
        do_load();
        c = 0;
        while (n_acc < 3 && c < 50) begin
            step();
            c++;
        end
        chk("stall_at3", 64'(n_acc), 64'd3);
        clk_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_valid", 64'(out_valid), 64'd0);
            chk("stall_data",  64'(out_data),  64'h40800000);
            step();
        end
        clk_en = 1'b1;
        wait_idle("stall_timeout");
        chk("stall_acc", 64'(n_acc), 64'd9);

        // Second matrix offered while streaming
        exp_q.delete(); n_acc = 0; expect_vals();
        for (int i = 0; i < 9; i++) exp_q.push_back(32'hC0000000);
        set_matrix(vals);
        do_load();
        step();
        step();
        set_matrix(neg2);
        load_req = 1'b1;
        c = 0;
        while (!(n_acc >= 9 && busy) && c < 100) begin
            step();
            c++;
        end
        load_req = 1'b0;
        chk("second_captured", 64'(busy), 64'd1);
        wait_idle("second_timeout");
        chk("second_acc",  64'(n_acc), 64'd18);
        chk("second_left", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset after the fifth transfer
        exp_q.delete(); n_acc = 0; expect_vals();
        set_matrix(vals);
        do_load();
        c = 0;
        while (n_acc < 5 && c < 50) begin
            step();
            c++;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid),  64'd0);
        chk("arst_busy",  64'(busy),       64'd0);
        chk("arst_ready", 64'(load_ready), 64'd1);
        rst = 1'b0;
        exp_q.delete(); n_acc = 0;
        step();
        chk("post_rst_ready", 64'(load_ready), 64'd1);
        expect_vals();
        do_load();
        wait_idle("post_rst_timeout");
        chk("post_rst_acc", 64'(n_acc), 64'd9);

        // 1x1 build
        load_matrix1 = 32'h3F800000;
        out_ready1 = 1'b1;
        load_req1 = 1'b1;
        step();
        load_req1 = 1'b0;
        chk("one_valid", 64'(out_valid1), 64'd1);
        chk("one_data",  64'(out_data1),  64'h3F800000);
        chk("one_last",  64'(out_last1),  64'd1);
        chk("one_idx",   64'({out_row1, out_col1}), 64'd0);
        step();
        chk("one_done_valid", 64'(out_valid1),  64'd0);
        chk("one_done_ready", 64'(load_ready1), 64'd1);
        chk("one_done_busy",  64'(busy1),       64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
